if_id_queue: RTL

Parametrised fetch-to-decode instruction buffer, the successor to the single-entry IF/ID pipeline register. Holds up to DEPTH fetched (pc, inst) pairs in a circular FIFO. Fetch keeps issuing while decode is stalled, and decode drains the backlog afterwards. Flush empties the queue in one cycle for exception handling. While the queue is empty, the decode side sees a zero bubble (pc = 0, inst = 0, nop), the same bubble the single-entry register produces.

---
 rtl/if_id_queue.sv | 72 +++++++
 1 files changed

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction buffer: a DEPTH-entry circular FIFO of (pc, inst)
// pairs that presents a zero bubble to decode whenever it is empty.
module if_id_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_valid,
  input  logic [ADDR_W-1:0]        if_pc,
  input  logic [INST_W-1:0]        if_inst,
  output logic                     if_ready,
  output logic                     id_valid,
  output logic [ADDR_W-1:0]        id_pc,
  output logic [INST_W-1:0]        id_inst,
  input  logic                     id_stall,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;

  // Handshakes come from registered occupancy only, so if_ready never sees id_stall.
  assign if_ready = (count != FULL);
  assign id_valid = (count != '0);
  assign push     = if_valid & if_ready;
  assign pop      = id_valid & ~id_stall;

  assign id_pc    = id_valid ? pc_mem[rd_ptr]   : '0;
  assign id_inst  = id_valid ? inst_mem[rd_ptr] : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately left out of reset; occupancy gates every read,
  // so stale contents are never visible and the arrays can map to plain flops/RAM.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pc_mem[wr_ptr]   <= if_pc;
      inst_mem[wr_ptr] <= if_inst;
    end
  end

endmodule
